cla_adder_nbit: RTL and testbench



---
 rtl/cla_adder_nbit.sv | 216 +++++++++++++++++++++
 tb/tb_cla_adder_nbit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_adder_nbit.sv
`default_nettype none
// ============================================================================
// Module      : cla_adder_nbit
// Description : Registered N-bit carry-lookahead adder.
//               {c_out, s_out} = a_in + b_in + c_in, exact modulo 2^(NUMBITS+1).
//               Each 4-bit leaf group forms bit propagate/generate terms,
//               two-level sum-of-products internal carries and group P/G.
//               A group-level carry unit chains the leaves. When NUMBITS is not
//               a multiple of 4, the top group is zero-extended internally.
//               Optional build macro: CLA_INPUT_REG_EN adds an input register
//               stage for a_in, b_in, c_in and in_valid. Latency becomes 2 and
//               throughput stays 1/cycle.
// Ports       : clk       - clock, rising-edge active
//               rst_n     - asynchronous, active-low reset
//               in_valid  - operands valid this cycle
//               a_in      - operand A, unsigned, NUMBITS wide
//               b_in      - operand B, unsigned, NUMBITS wide
//               c_in      - carry in
//               out_valid - s_out/c_out hold a new result (one cycle per result)
//               s_out     - sum, NUMBITS wide
//               c_out     - carry out of bit NUMBITS-1
// Parameters  : NUMBITS   - operand/sum width, any value >= 1
// Revision    : 1.0 - initial release
// ============================================================================
module cla_adder_nbit #(
    parameter int NUMBITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [NUMBITS-1:0] a_in,
    input  logic [NUMBITS-1:0] b_in,
    input  logic               c_in,
    output logic               out_valid,
    output logic [NUMBITS-1:0] s_out,
    output logic               c_out
);

    // Number of 4-bit leaf groups and the zero-extended internal width.
    localparam int c_num_groups = (NUMBITS + 3) / 4;
    localparam int c_pad_width  = c_num_groups * 4;

    // Operands as seen by the lookahead logic (direct or registered).
    logic [NUMBITS-1:0] w_op_a;
    logic [NUMBITS-1:0] w_op_b;
    logic               w_op_c;
    logic               w_op_valid;

    // ------------------------------------------------------------------------
    // Optional input register stage
    // ------------------------------------------------------------------------
`ifdef CLA_INPUT_REG_EN
    logic [NUMBITS-1:0] r_a_q;
    logic [NUMBITS-1:0] w_a_d;
    logic [NUMBITS-1:0] r_b_q;
    logic [NUMBITS-1:0] w_b_d;
    logic               r_cin_q;
    logic               w_cin_d;
    logic               r_in_valid_q;
    logic               w_in_valid_d;

    // Operands are captured every cycle; only the valid tag decides whether
    // the output stage later loads them.
    always_comb begin
        w_a_d        = a_in;
        w_b_d        = b_in;
        w_cin_d      = c_in;
        w_in_valid_d = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_q        <= '0;
            r_b_q        <= '0;
            r_cin_q      <= 1'b0;
            r_in_valid_q <= 1'b0;
        end else begin
            r_a_q        <= w_a_d;
            r_b_q        <= w_b_d;
            r_cin_q      <= w_cin_d;
            r_in_valid_q <= w_in_valid_d;
        end
    end

    assign w_op_a     = r_a_q;
    assign w_op_b     = r_b_q;
    assign w_op_c     = r_cin_q;
    assign w_op_valid = r_in_valid_q;
`else
    assign w_op_a     = a_in;
    assign w_op_b     = b_in;
    assign w_op_c     = c_in;
    assign w_op_valid = in_valid;
`endif

    // ------------------------------------------------------------------------
    // Zero extension to a whole number of leaf groups
    // ------------------------------------------------------------------------
    logic [c_pad_width-1:0] w_a_pad;
    logic [c_pad_width-1:0] w_b_pad;

    always_comb begin
        w_a_pad                = '0;
        w_b_pad                = '0;
        w_a_pad[NUMBITS-1:0]   = w_op_a;
        w_b_pad[NUMBITS-1:0]   = w_op_b;
    end

    // Bit-level propagate / generate.
    logic [c_pad_width-1:0] w_p;
    logic [c_pad_width-1:0] w_g;

    assign w_p = w_a_pad ^ w_b_pad;
    assign w_g = w_a_pad & w_b_pad;

    // w_c[i] is the carry into bit i; w_c[c_pad_width] is the padded carry out.
    logic [c_pad_width:0]    w_c;
    // w_gc[k] is the carry into group k, produced by the group carry unit.
    logic [c_num_groups:0]   w_gc;
    logic [c_num_groups-1:0] w_grp_p;
    logic [c_num_groups-1:0] w_grp_g;

    assign w_gc[0] = w_op_c;

    // ------------------------------------------------------------------------
    // 4-bit CLA leaf groups and the group-level carry chain
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < c_num_groups; k++) begin : g_group
        logic [3:0] w_lp;
        logic [3:0] w_lg;
        logic       w_ci;

        assign w_lp = w_p[4*k +: 4];
        assign w_lg = w_g[4*k +: 4];
        assign w_ci = w_gc[k];

        // Internal carries flattened to two-level sum-of-products so every
        // bit carry depends only on the group carry-in, never on a ripple.
        assign w_c[4*k]   = w_ci;
        assign w_c[4*k+1] = w_lg[0]
                          | (w_lp[0] & w_ci);
        assign w_c[4*k+2] = w_lg[1]
                          | (w_lp[1] & w_lg[0])
                          | (w_lp[1] & w_lp[0] & w_ci);
        assign w_c[4*k+3] = w_lg[2]
                          | (w_lp[2] & w_lg[1])
                          | (w_lp[2] & w_lp[1] & w_lg[0])
                          | (w_lp[2] & w_lp[1] & w_lp[0] & w_ci);

        // Group propagate / generate, independent of the carry-in.
        assign w_grp_p[k] = &w_lp;
        assign w_grp_g[k] = w_lg[3]
                          | (w_lp[3] & w_lg[2])
                          | (w_lp[3] & w_lp[2] & w_lg[1])
                          | (w_lp[3] & w_lp[2] & w_lp[1] & w_lg[0]);

        // Group carry unit.
        assign w_gc[k+1] = w_grp_g[k] | (w_grp_p[k] & w_gc[k]);
    end

    assign w_c[c_pad_width] = w_gc[c_num_groups];

    // With a padded top group the carries above bit NUMBITS carry no
    // information (operands are zero there); they are collected here only so
    // they are visibly consumed.
    if (c_pad_width > NUMBITS) begin : g_pad_sink
        logic w_unused_pad_carry;
        assign w_unused_pad_carry = ^w_c[c_pad_width:NUMBITS+1];
    end else begin : g_no_pad_sink
    end

    // Sum bits and the true carry into bit NUMBITS (not the padded group carry).
    logic [NUMBITS-1:0] w_sum;
    logic               w_carry;

    assign w_sum   = w_p[NUMBITS-1:0] ^ w_c[NUMBITS-1:0];
    assign w_carry = w_c[NUMBITS];

    // ------------------------------------------------------------------------
    // Output register: loads on valid, holds otherwise
    // ------------------------------------------------------------------------
    logic [NUMBITS-1:0] r_s_q;
    logic [NUMBITS-1:0] w_s_d;
    logic               r_co_q;
    logic               w_co_d;
    logic               r_valid_q;
    logic               w_valid_d;

    always_comb begin
        w_s_d     = r_s_q;
        w_co_d    = r_co_q;
        w_valid_d = w_op_valid;
        if (w_op_valid) begin
            w_s_d  = w_sum;
            w_co_d = w_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q     <= '0;
            r_co_q    <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            r_s_q     <= w_s_d;
            r_co_q    <= w_co_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign s_out     = r_s_q;
    assign c_out     = r_co_q;
    assign out_valid = r_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_adder_nbit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_adder_nbit
// Description : Directed self-checking bench for cla_adder_nbit at NUMBITS of
//               4, 8 and 6. Expected values are hand-computed sums.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_adder_nbit;

`ifdef CLA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;

    logic [3:0] a4, b4;
    logic       c4;
    logic       v4_o;
    logic [3:0] s4_o;
    logic       co4_o;

    logic [7:0] a8, b8;
    logic       c8;
    logic       v8_o;
    logic [7:0] s8_o;
    logic       co8_o;

    logic [5:0] a6, b6;
    logic       c6;
    logic       v6_o;
    logic [5:0] s6_o;
    logic       co6_o;

    int n_cmp = 0;
    int n_err = 0;

    cla_adder_nbit #(.NUMBITS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a_in(a4), .b_in(b4), .c_in(c4),
        .out_valid(v4_o), .s_out(s4_o), .c_out(co4_o)
    );

    cla_adder_nbit #(.NUMBITS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a_in(a8), .b_in(b8), .c_in(c8),
        .out_valid(v8_o), .s_out(s8_o), .c_out(co8_o)
    );

    cla_adder_nbit #(.NUMBITS(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a_in(a6), .b_in(b6), .c_in(c6),
        .out_valid(v6_o), .s_out(s6_o), .c_out(co6_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reset asserted from time zero: outputs must be zero before any edge
    // and across edges while rst_n stays low.
    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a4 = 4'd3;  b4 = 4'd4;  c4 = 1'b1;
        a8 = 8'd10; b8 = 8'd20; c8 = 1'b0;
        a6 = 6'd5;  b6 = 6'd6;  c6 = 1'b1;
        #2;
        n_cmp++;
        if ({v4_o, co4_o, s4_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_async_dut4: got %b expected 000000", {v4_o, co4_o, s4_o});
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({v4_o, co4_o, s4_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_held_dut4: got %b expected 000000", {v4_o, co4_o, s4_o});
        end
        n_cmp++;
        if ({v8_o, co8_o, s8_o} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_held_dut8: got %b expected 0", {v8_o, co8_o, s8_o});
        end
        n_cmp++;
        if ({v6_o, co6_o, s6_o} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_held_dut6: got %b expected 0", {v6_o, co6_o, s6_o});
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Exhaustive NUMBITS=4 sweep, one operand set per cycle.
    task automatic test_exhaustive4();
        logic [4:0] exp_sum [512];
        int idx;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    idx = a * 32 + b * 2 + c;
                    exp_sum[idx] = 5'(a + b + c);
                end
            end
        end
        for (int i = 0; i < 512; i++) begin
            a4 = 4'(i / 32);
            b4 = 4'((i / 2) % 16);
            c4 = 1'(i % 2);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            if (i >= LAT - 1) begin
                n_cmp++;
                if ({v4_o, co4_o, s4_o} !== {1'b1, exp_sum[i-LAT+1]}) begin
                    n_err++;
                    $display("FAIL exhaustive4 vec %0d: got v=%b sum=%0d expected v=1 sum=%0d",
                             i - LAT + 1, v4_o, {co4_o, s4_o}, exp_sum[i-LAT+1]);
                end
            end
        end
        in_valid = 1'b0;
        for (int d = 0; d < LAT - 1; d++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({v4_o, co4_o, s4_o} !== {1'b1, exp_sum[512-LAT+1+d]}) begin
                n_err++;
                $display("FAIL exhaustive4 drain %0d: got v=%b sum=%0d expected v=1 sum=%0d",
                         d, v4_o, {co4_o, s4_o}, exp_sum[512-LAT+1+d]);
            end
        end
        // Idle edge: valid drops, last result (15+15+1=31) is held.
        @(posedge clk);
        #1;
        n_cmp++;
        if ({v4_o, co4_o, s4_o} !== 6'b0_11111) begin
            n_err++;
            $display("FAIL exhaustive4 idle_hold: got %b expected 011111", {v4_o, co4_o, s4_o});
        end
    endtask

    // Boundary operands for all three widths, two operand sets.
    task automatic test_corners();
        logic [4:0] e4 [2];
        logic [8:0] e8 [2];
        logic [6:0] e6 [2];
        e4[0] = {1'b1, 4'd15}; e4[1] = {1'b0, 4'd15};
        e8[0] = {1'b1, 8'd0};  e8[1] = {1'b1, 8'd0};
        e6[0] = {1'b1, 6'd0};  e6[1] = {1'b0, 6'd63};
        for (int v = 0; v < 2; v++) begin
            if (v == 0) begin
                a4 = 4'd15;  b4 = 4'd15; c4 = 1'b1;
                a8 = 8'd255; b8 = 8'd1;  c8 = 1'b0;
                a6 = 6'd63;  b6 = 6'd0;  c6 = 1'b1;
            end else begin
                a4 = 4'd7;   b4 = 4'd8;   c4 = 1'b0;
                a8 = 8'd128; b8 = 8'd127; c8 = 1'b1;
                a6 = 6'd32;  b6 = 6'd31;  c6 = 1'b0;
            end
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            repeat (LAT - 1) begin
                @(posedge clk);
                #1;
            end
            n_cmp++;
            if ({v4_o, co4_o, s4_o} !== {1'b1, e4[v]}) begin
                n_err++;
                $display("FAIL corner4 set %0d: got v=%b c=%b s=%0d expected v=1 c=%b s=%0d",
                         v, v4_o, co4_o, s4_o, e4[v][4], e4[v][3:0]);
            end
            n_cmp++;
            if ({v8_o, co8_o, s8_o} !== {1'b1, e8[v]}) begin
                n_err++;
                $display("FAIL corner8 set %0d: got v=%b c=%b s=%0d expected v=1 c=%b s=%0d",
                         v, v8_o, co8_o, s8_o, e8[v][8], e8[v][7:0]);
            end
            n_cmp++;
            if ({v6_o, co6_o, s6_o} !== {1'b1, e6[v]}) begin
                n_err++;
                $display("FAIL corner6 set %0d: got v=%b c=%b s=%0d expected v=1 c=%b s=%0d",
                         v, v6_o, co6_o, s6_o, e6[v][6], e6[v][5:0]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Stream 3 valid, 1 invalid, 2 valid; the invalid slot holds the 3rd sum.
    task automatic test_valid_gating();
        logic [3:0] va [6];
        logic [3:0] vb [6];
        logic       vc [6];
        logic       vv [6];
        logic       ev [6];
        logic [4:0] ed [6];
        va = '{4'd1, 4'd3, 4'd5, 4'd9, 4'd2, 4'd15};
        vb = '{4'd2, 4'd4, 4'd5, 4'd9, 4'd2, 4'd0};
        vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ev = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ed = '{5'd3, 5'd7, 5'd11, 5'd11, 5'd4, 5'd15};
        for (int i = 0; i < 6; i++) begin
            a4 = va[i]; b4 = vb[i]; c4 = vc[i];
            in_valid = vv[i];
            @(posedge clk);
            #1;
            if (i >= LAT - 1) begin
                n_cmp++;
                if ({v4_o, co4_o, s4_o} !== {ev[i-LAT+1], ed[i-LAT+1]}) begin
                    n_err++;
                    $display("FAIL valid_gating slot %0d: got v=%b sum=%0d expected v=%b sum=%0d",
                             i - LAT + 1, v4_o, {co4_o, s4_o}, ev[i-LAT+1], ed[i-LAT+1]);
                end
            end
        end
        in_valid = 1'b0;
        for (int d = 0; d < LAT - 1; d++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({v4_o, co4_o, s4_o} !== {ev[6-LAT+1+d], ed[6-LAT+1+d]}) begin
                n_err++;
                $display("FAIL valid_gating drain %0d: got v=%b sum=%0d expected v=%b sum=%0d",
                         d, v4_o, {co4_o, s4_o}, ev[6-LAT+1+d], ed[6-LAT+1+d]);
            end
        end
    endtask

    // Reset asserted between edges while a result is presented.
    task automatic test_reset_midstream();
        a4 = 4'd6; b4 = 4'd7; c4 = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (LAT - 1) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if ({v4_o, co4_o, s4_o} !== 6'b1_01110) begin
            n_err++;
            $display("FAIL midreset_pre: got %b expected 101110", {v4_o, co4_o, s4_o});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({v4_o, co4_o, s4_o} !== 6'b0) begin
            n_err++;
            $display("FAIL midreset_async: got %b expected 000000", {v4_o, co4_o, s4_o});
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'd9; b4 = 4'd4; c4 = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < LAT - 1; k++) begin
            n_cmp++;
            if ({v4_o, co4_o, s4_o} !== 6'b0) begin
                n_err++;
                $display("FAIL midreset_wait %0d: got %b expected 000000", k, {v4_o, co4_o, s4_o});
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if ({v4_o, co4_o, s4_o} !== 6'b1_01101) begin
            n_err++;
            $display("FAIL midreset_first: got %b expected 101101", {v4_o, co4_o, s4_o});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({v4_o, co4_o, s4_o} !== 6'b0_01101) begin
            n_err++;
            $display("FAIL midreset_hold: got %b expected 001101", {v4_o, co4_o, s4_o});
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive4();
        test_corners();
        test_valid_gating();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
